// File: rtl/face_region_locator.sv
// Sweeps a GRID_W x GRID_H XYZ buffer once per START, classifies skin pixels and reports count,
// face flag and bounding box. Define FACE_LOCATOR_CENTROID_EN to add centroid outputs (DIVIDE state).
module face_region_locator #(
   parameter int          GRID_W     = 20,
   parameter int          GRID_H     = 20,
   parameter logic [31:0] Y_MIN      = 32'd2000,
   parameter logic [31:0] Y_MAX      = 32'd60000,
   parameter logic [9:0]  CX_LO      = 10'd330,
   parameter logic [9:0]  CX_HI      = 10'd430,
   parameter logic [9:0]  CY_LO      = 10'd300,
   parameter logic [9:0]  CY_HI      = 10'd380,
   parameter logic [8:0]  MIN_PIXELS = 9'd12
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   output logic               RD_EN,
   output logic [8:0]         RD_ADDR,
   input  logic signed [31:0] X_IN,
   input  logic signed [31:0] Y_IN,
   input  logic signed [31:0] Z_IN,
   output logic               BUSY,
   output logic               DONE,
   output logic               FACE_FOUND,
   output logic [8:0]         SKIN_COUNT,
   output logic [4:0]         COL_MIN,
   output logic [4:0]         COL_MAX,
   output logic [4:0]         ROW_MIN,
   output logic [4:0]         ROW_MAX
`ifdef FACE_LOCATOR_CENTROID_EN
   ,
   output logic [4:0]         CENT_COL,
   output logic [4:0]         CENT_ROW
`endif
);

   localparam logic [8:0] LAST_ADDR = 9'(GRID_W * GRID_H - 1);
   localparam logic [4:0] LAST_COL  = 5'(GRID_W - 1);

`ifdef FACE_LOCATOR_CENTROID_EN
   typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_READ = 3'd1, ST_DRAIN = 3'd2,
                             ST_REPORT = 3'd3, ST_DIVIDE = 3'd4} state_t;
   localparam state_t AFTER_DRAIN = ST_DIVIDE;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_DRAIN = 2'd2,
                             ST_REPORT = 2'd3} state_t;
   localparam state_t AFTER_DRAIN = ST_REPORT;
`endif

   state_t state_r, state_s;
   logic       rd_en_r, busy_r, done_r, drain_cnt_r;
   logic [8:0] rd_addr_r;
   logic [4:0] col_r, row_r, col_d1_r, row_d1_r, col_s1_r, row_s1_r;
   logic       vld_d1_r, vld_s1_r;
   logic signed [31:0] x_s1_r, y_s1_r, z_s1_r;
   logic signed [33:0] sum_s;
   logic signed [63:0] x_w_s, y_w_s, s_w_s;
   logic       skin_s;
   logic [8:0] cnt_r, cnt_s;
   logic [4:0] cmin_r, cmax_r, rmin_r, rmax_r, cmin_s, cmax_s, rmin_s, rmax_s;
   logic       face_r;
   logic [8:0] count_out_r;
   logic [4:0] cmin_out_r, cmax_out_r, rmin_out_r, rmax_out_r;
`ifdef FACE_LOCATOR_CENTROID_EN
   logic [12:0] csum_r, rsum_r, csum_s, rsum_s, crem_r, rrem_r, crem_nx_s, rrem_nx_s;
   logic [13:0] div_s;
   logic [4:0]  cq_r, rq_r, cq_nx_s, rq_nx_s, ccent_out_r, rcent_out_r;
   logic [2:0]  div_it_r;
`endif

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:   if (START) state_s = ST_READ; else state_s = ST_IDLE;
         ST_READ:   if (rd_addr_r == LAST_ADDR) state_s = ST_DRAIN; else state_s = ST_READ;
         ST_DRAIN:  if (drain_cnt_r) state_s = AFTER_DRAIN; else state_s = ST_DRAIN;
`ifdef FACE_LOCATOR_CENTROID_EN
         ST_DIVIDE: if (div_it_r == 3'd0) state_s = ST_REPORT; else state_s = ST_DIVIDE;
`endif
         ST_REPORT: state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // Read address generation, drain timer and status flags
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_en_r     <= 1'b0;
         rd_addr_r   <= 9'd0;
         col_r       <= 5'd0;
         row_r       <= 5'd0;
         drain_cnt_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         rd_en_r <= (state_s == ST_READ);
         busy_r  <= (state_s != ST_IDLE) && (state_s != ST_REPORT);
         done_r  <= (state_s == ST_REPORT);
         if (state_r == ST_DRAIN) drain_cnt_r <= ~drain_cnt_r;
         else                     drain_cnt_r <= 1'b0;
         if ((state_s == ST_READ) && (state_r == ST_READ)) begin
            rd_addr_r <= rd_addr_r + 9'd1;
            if (col_r == LAST_COL) begin
               col_r <= 5'd0;
               row_r <= row_r + 5'd1;
            end else begin
               col_r <= col_r + 5'd1;
               row_r <= row_r;
            end
         end else begin
            rd_addr_r <= 9'd0;
            col_r     <= 5'd0;
            row_r     <= 5'd0;
         end
      end
   end

   // Pixel pipeline: coordinates wait one cycle for the buffer, then travel with the sample
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vld_d1_r <= 1'b0;
         col_d1_r <= 5'd0;
         row_d1_r <= 5'd0;
         vld_s1_r <= 1'b0;
         x_s1_r   <= 32'sd0;
         y_s1_r   <= 32'sd0;
         z_s1_r   <= 32'sd0;
         col_s1_r <= 5'd0;
         row_s1_r <= 5'd0;
      end else begin
         vld_d1_r <= rd_en_r;
         col_d1_r <= col_r;
         row_d1_r <= row_r;
         vld_s1_r <= vld_d1_r;
         if (vld_d1_r) begin
            x_s1_r   <= X_IN;
            y_s1_r   <= Y_IN;
            z_s1_r   <= Z_IN;
            col_s1_r <= col_d1_r;
            row_s1_r <= row_d1_r;
         end else begin
            x_s1_r   <= x_s1_r;
            y_s1_r   <= y_s1_r;
            z_s1_r   <= z_s1_r;
            col_s1_r <= col_s1_r;
            row_s1_r <= row_s1_r;
         end
      end
   end

   // Skin classifier: chromaticity ratios compared by cross-multiplication against S
   always_comb begin
      sum_s = $signed({{2{x_s1_r[31]}}, x_s1_r}) + $signed({{2{y_s1_r[31]}}, y_s1_r})
            + $signed({{2{z_s1_r[31]}}, z_s1_r});
      s_w_s = $signed({{30{sum_s[33]}}, sum_s});
      x_w_s = $signed({{32{x_s1_r[31]}}, x_s1_r}) <<< 10;
      y_w_s = $signed({{32{y_s1_r[31]}}, y_s1_r});
      skin_s = vld_s1_r
            && (x_s1_r > 32'sd0) && (y_s1_r > 32'sd0) && (z_s1_r > 32'sd0)
            && (y_w_s >= $signed({32'd0, Y_MIN})) && (y_w_s <= $signed({32'd0, Y_MAX}))
            && ($signed({54'd0, CX_LO}) * s_w_s <= x_w_s)
            && (x_w_s <= $signed({54'd0, CX_HI}) * s_w_s)
            && ($signed({54'd0, CY_LO}) * s_w_s <= (y_w_s <<< 10))
            && ((y_w_s <<< 10) <= $signed({54'd0, CY_HI}) * s_w_s);
   end

   // Accumulator update for the pixel in stage 2
   always_comb begin
      cnt_s  = cnt_r;
      cmin_s = cmin_r;
      cmax_s = cmax_r;
      rmin_s = rmin_r;
      rmax_s = rmax_r;
      if (skin_s) begin
         cnt_s = cnt_r + 9'd1;
         if (col_s1_r < cmin_r) cmin_s = col_s1_r; else cmin_s = cmin_r;
         if (col_s1_r > cmax_r) cmax_s = col_s1_r; else cmax_s = cmax_r;
         if (row_s1_r < rmin_r) rmin_s = row_s1_r; else rmin_s = rmin_r;
         if (row_s1_r > rmax_r) rmax_s = row_s1_r; else rmax_s = rmax_r;
      end else begin
         cnt_s = cnt_r;
      end
   end

`ifdef FACE_LOCATOR_CENTROID_EN
   // Coordinate sums and one restoring-divider step per DIVIDE cycle, MSB first
   always_comb begin
      csum_s = csum_r;
      rsum_s = rsum_r;
      if (skin_s) begin
         csum_s = csum_r + {8'd0, col_s1_r};
         rsum_s = rsum_r + {8'd0, row_s1_r};
      end else begin
         csum_s = csum_r;
      end
      div_s     = {5'd0, cnt_r} << div_it_r;
      crem_nx_s = crem_r;
      cq_nx_s   = cq_r;
      rrem_nx_s = rrem_r;
      rq_nx_s   = rq_r;
      if ({1'b0, crem_r} >= div_s) begin
         crem_nx_s = crem_r - div_s[12:0];
         cq_nx_s   = cq_r | (5'd1 << div_it_r);
      end else begin
         crem_nx_s = crem_r;
      end
      if ({1'b0, rrem_r} >= div_s) begin
         rrem_nx_s = rrem_r - div_s[12:0];
         rq_nx_s   = rq_r | (5'd1 << div_it_r);
      end else begin
         rrem_nx_s = rrem_r;
      end
   end

   // Divider registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         crem_r <= 13'd0; rrem_r <= 13'd0;
         cq_r <= 5'd0; rq_r <= 5'd0;
         div_it_r <= 3'd0;
      end else if ((state_r == ST_DRAIN) && (state_s == ST_DIVIDE)) begin
         crem_r <= csum_s; rrem_r <= rsum_s;
         cq_r <= 5'd0; rq_r <= 5'd0;
         div_it_r <= 3'd4;
      end else if (state_r == ST_DIVIDE) begin
         crem_r <= crem_nx_s; rrem_r <= rrem_nx_s;
         cq_r <= cq_nx_s; rq_r <= rq_nx_s;
         div_it_r <= div_it_r - 3'd1;
      end else begin
         div_it_r <= div_it_r;
      end
   end
`endif

   // Accumulators, cleared on the accepted START
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_r <= 9'd0; cmin_r <= 5'd31; cmax_r <= 5'd0; rmin_r <= 5'd31; rmax_r <= 5'd0;
`ifdef FACE_LOCATOR_CENTROID_EN
         csum_r <= 13'd0; rsum_r <= 13'd0;
`endif
      end else if ((state_r == ST_IDLE) && START) begin
         cnt_r <= 9'd0; cmin_r <= 5'd31; cmax_r <= 5'd0; rmin_r <= 5'd31; rmax_r <= 5'd0;
`ifdef FACE_LOCATOR_CENTROID_EN
         csum_r <= 13'd0; rsum_r <= 13'd0;
`endif
      end else begin
         cnt_r <= cnt_s; cmin_r <= cmin_s; cmax_r <= cmax_s; rmin_r <= rmin_s; rmax_r <= rmax_s;
`ifdef FACE_LOCATOR_CENTROID_EN
         csum_r <= csum_s; rsum_r <= rsum_s;
`endif
      end
   end

   // Result registers; the final pixel lands on the same edge, so load from the next-values
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         face_r <= 1'b0; count_out_r <= 9'd0;
         cmin_out_r <= 5'd0; cmax_out_r <= 5'd0; rmin_out_r <= 5'd0; rmax_out_r <= 5'd0;
`ifdef FACE_LOCATOR_CENTROID_EN
         ccent_out_r <= 5'd0; rcent_out_r <= 5'd0;
`endif
      end else if (state_s == ST_REPORT) begin
         count_out_r <= cnt_s;
         face_r      <= (cnt_s >= MIN_PIXELS);
         if (cnt_s == 9'd0) begin
            cmin_out_r <= 5'd0; cmax_out_r <= 5'd0; rmin_out_r <= 5'd0; rmax_out_r <= 5'd0;
`ifdef FACE_LOCATOR_CENTROID_EN
            ccent_out_r <= 5'd0; rcent_out_r <= 5'd0;
`endif
         end else begin
            cmin_out_r <= cmin_s; cmax_out_r <= cmax_s; rmin_out_r <= rmin_s; rmax_out_r <= rmax_s;
`ifdef FACE_LOCATOR_CENTROID_EN
            ccent_out_r <= cq_nx_s; rcent_out_r <= rq_nx_s;
`endif
         end
      end else begin
         face_r <= face_r;
      end
   end

   assign RD_EN      = rd_en_r;
   assign RD_ADDR    = rd_addr_r;
   assign BUSY       = busy_r;
   assign DONE       = done_r;
   assign FACE_FOUND = face_r;
   assign SKIN_COUNT = count_out_r;
   assign COL_MIN    = cmin_out_r;
   assign COL_MAX    = cmax_out_r;
   assign ROW_MIN    = rmin_out_r;
   assign ROW_MAX    = rmax_out_r;
`ifdef FACE_LOCATOR_CENTROID_EN
   assign CENT_COL   = ccent_out_r;
   assign CENT_ROW   = rcent_out_r;
`endif

endmodule

// File: tb/tb_face_region_locator.sv
// Directed bench for face_region_locator: a 400-entry buffer model answers reads one cycle later;
// each sweep checks read sequence, BUSY/DONE timing and the reported results.
module tb_face_region_locator;

   localparam int NPIX = 400;
`ifdef FACE_LOCATOR_CENTROID_EN
   localparam int DONE_CYC = 408;
`else
   localparam int DONE_CYC = 403;
`endif

   logic               CLK = 1'b0;
   logic               RST_N = 1'b0;
   logic               START = 1'b0;
   logic               RD_EN;
   logic [8:0]         RD_ADDR;
   logic signed [31:0] X_IN = 32'sd0;
   logic signed [31:0] Y_IN = 32'sd0;
   logic signed [31:0] Z_IN = 32'sd0;
   logic               BUSY, DONE, FACE_FOUND;
   logic [8:0]         SKIN_COUNT;
   logic [4:0]         COL_MIN, COL_MAX, ROW_MIN, ROW_MAX;
   logic [63:0]        outs;
`ifdef FACE_LOCATOR_CENTROID_EN
   logic [4:0]         CENT_COL, CENT_ROW;
   assign outs = {12'd0, RD_EN, BUSY, DONE, FACE_FOUND, SKIN_COUNT, COL_MIN, COL_MAX,
                  ROW_MIN, ROW_MAX, RD_ADDR, CENT_COL, CENT_ROW};
`else
   assign outs = {22'd0, RD_EN, BUSY, DONE, FACE_FOUND, SKIN_COUNT, COL_MIN, COL_MAX,
                  ROW_MIN, ROW_MAX, RD_ADDR};
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int mx [NPIX];
   int my [NPIX];
   int mz [NPIX];

   face_region_locator dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
      .X_IN(X_IN), .Y_IN(Y_IN), .Z_IN(Z_IN), .BUSY(BUSY), .DONE(DONE),
      .FACE_FOUND(FACE_FOUND), .SKIN_COUNT(SKIN_COUNT),
      .COL_MIN(COL_MIN), .COL_MAX(COL_MAX), .ROW_MIN(ROW_MIN), .ROW_MAX(ROW_MAX)
`ifdef FACE_LOCATOR_CENTROID_EN
      , .CENT_COL(CENT_COL), .CENT_ROW(CENT_ROW)
`endif
   );

   always #5 CLK = ~CLK;

   // Frame buffer model: data for a read appears the cycle after RD_EN
   always @(posedge CLK) begin
      if (RD_EN) begin
         X_IN <= mx[RD_ADDR];
         Y_IN <= my[RD_ADDR];
         Z_IN <= mz[RD_ADDR];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic set_px(input int a, input int x, input int y, input int z);
      mx[a] = x; my[a] = y; mz[a] = z;
   endtask

   task automatic fill_uniform(input int v);
      for (int a = 0; a < NPIX; a++) set_px(a, v, v, v);
   endtask

   task automatic fill_block();
      fill_uniform(0);
      for (int r = 10; r <= 12; r++)
         for (int c = 5; c <= 8; c++) set_px(r * 20 + c, 10000, 10000, 10000);
   endtask

   // One sweep; extra_start / rst_at give the cycle of a stray START or a reset (0 = none)
   task automatic run_frame(input string name, input int extra_start, input int rst_at,
                            input int e_cnt, input int e_face, input int e_cmin, input int e_cmax,
                            input int e_rmin, input int e_rmax, input int e_ccol, input int e_crow);
      int rd_err = 0, addr_err = 0, busy_err = 0, done_err = 0, done_cnt = 0;
      bit in_run, exp_rd;
      @(negedge CLK);
      START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      for (int n = 1; n <= DONE_CYC + 4; n++) begin
         @(negedge CLK);
         if ((extra_start != 0) && (n == extra_start)) START = 1'b1;
         else START = 1'b0;
         if ((rst_at != 0) && (n == rst_at)) begin
            RST_N = 1'b0;
            #1 check({name, "_outs_at_reset"}, outs, 64'd0);
         end
         if ((rst_at != 0) && (n == rst_at + 2)) RST_N = 1'b1;
         in_run = (rst_at == 0) || (n < rst_at);
         exp_rd = in_run && (n <= NPIX);
         if (RD_EN !== exp_rd) rd_err++;
         if (exp_rd && (RD_ADDR !== 9'(n - 1))) addr_err++;
         if (BUSY !== (in_run && (n < DONE_CYC))) busy_err++;
         if (DONE !== (in_run && (n == DONE_CYC))) done_err++;
         if (DONE === 1'b1) done_cnt++;
      end
      check({name, "_rd_en_errs"}, rd_err, 0);
      check({name, "_rd_addr_errs"}, addr_err, 0);
      check({name, "_busy_errs"}, busy_err, 0);
      check({name, "_done_timing_errs"}, done_err, 0);
      check({name, "_done_pulses"}, done_cnt, (rst_at == 0) ? 1 : 0);
      if (rst_at != 0) begin
         check({name, "_outs_after_abort"}, outs, 64'd0);
      end else begin
         check({name, "_skin_count"}, SKIN_COUNT, e_cnt);
         check({name, "_face_found"}, FACE_FOUND, e_face);
         check({name, "_col_min"}, COL_MIN, e_cmin);
         check({name, "_col_max"}, COL_MAX, e_cmax);
         check({name, "_row_min"}, ROW_MIN, e_rmin);
         check({name, "_row_max"}, ROW_MAX, e_rmax);
`ifdef FACE_LOCATOR_CENTROID_EN
         check({name, "_cent_col"}, CENT_COL, e_ccol);
         check({name, "_cent_row"}, CENT_ROW, e_crow);
`endif
      end
   endtask

   initial begin
      fill_uniform(0);
      repeat (3) @(posedge CLK);
      #1 check("reset_outputs", outs, 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      fill_uniform(10000);
      run_frame("uniform", 0, 0, 400, 1, 0, 19, 0, 19, 9, 9);

      fill_block();
      run_frame("block", 0, 0, 12, 1, 5, 8, 10, 12, 6, 11);

      fill_uniform(0);
      set_px(0, 10000, 10000, 10000);
      set_px(399, 10000, 10000, 10000);
      run_frame("corners", 0, 0, 2, 0, 0, 19, 0, 19, 9, 9);

      // Y at Y_MAX with 1024*X == CX_LO*S (kept), Y at Y_MIN (kept); the rest rejected
      fill_uniform(0);
      set_px(3 * 20 + 4, 59400, 60000, 64920);
      set_px(7 * 20 + 9, 1980, 2000, 2164);
      set_px(15 * 20 + 17, 59400, 60001, 64919);
      set_px(1 * 20 + 0, 59399, 60000, 64921);
      set_px(18 * 20 + 1, 10000, 10000, -10000);
      run_frame("boundary", 0, 0, 2, 0, 4, 9, 3, 7, 6, 5);

      fill_uniform(1000);
      run_frame("dim", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      fill_block();
      run_frame("stray_start", 100, 0, 12, 1, 5, 8, 10, 12, 6, 11);

      fill_uniform(10000);
      run_frame("abort", 0, 200, 0, 0, 0, 0, 0, 0, 0, 0);
      run_frame("fresh", 0, 0, 400, 1, 0, 19, 0, 19, 9, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
